arbitro_memoria_dados: RTL and testbench

- Shares the single-port 16-bit data memory between two requesters.
  - Requester P is the pipeline EX/MEM stage (load/store).
  - Requester X is the external loader/debug port (program/data upload, memory dump).
- Pipeline has fixed priority. A starvation counter guarantees X forward progress, and an X lock supports uninterrupted bursts.
- Sits between the EX/MEM stage and Memoria_Dados.
  - Drives the memory's write-enable, address and write-data.
  - Stalls the pipeline when P loses arbitration.

---
 rtl/arbitro_memoria_dados_pkg.sv | 13 +
 rtl/arbitro_memoria_dados_if.sv | 43 ++++
 rtl/arbitro_memoria_dados_contador_saturado.sv | 42 ++++
 rtl/arbitro_memoria_dados.sv | 130 +++++++++++++
 tb/tb_arbitro_memoria_dados.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared types for the data-memory arbiter: arbitration states and the memory word.
package pkg_memoria;

    localparam int unsigned LARGURA_DADOS = 16;

    typedef logic [LARGURA_DADOS-1:0] t_palavra;

    typedef enum logic {
        LIVRE,
        RAJADA_X
    } t_estado_arb;

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface arbitro_memoria_dados_if
    import pkg_memoria::*;
#(
    parameter int unsigned LARGURA = LARGURA_DADOS
);

    logic               req_p;
    logic               esc_p;
    logic [LARGURA-1:0] end_p;
    logic [LARGURA-1:0] dado_p;
    logic               stall_p;
    logic               pronto_p;

    logic               req_x;
    logic               esc_x;
    logic [LARGURA-1:0] end_x;
    logic [LARGURA-1:0] dado_x;
    logic               trava_x;
    logic               conc_x;
    logic               pronto_x;

    logic               md_hab_escrita;
    logic [LARGURA-1:0] md_endereco;
    logic [LARGURA-1:0] md_entrada;
    logic [LARGURA-1:0] md_saida;
    logic [LARGURA-1:0] dado_lido;

    // Arbiter side.
    modport slave (
        input  req_p, esc_p, end_p, dado_p, req_x, esc_x, end_x, dado_x, trava_x, md_saida,
        output stall_p, pronto_p, conc_x, pronto_x, md_hab_escrita, md_endereco, md_entrada,
        output dado_lido
    );

    // Requesters and memory side.
    modport master (
        output req_p, esc_p, end_p, dado_p, req_x, esc_x, end_x, dado_x, trava_x, md_saida,
        input  stall_p, pronto_p, conc_x, pronto_x, md_hab_escrita, md_endereco, md_entrada,
        input  dado_lido
    );

endinterface

// File: rtl/arbitro_memoria_dados_contador_saturado.sv
// Saturating up-counter with clear, load-to-one and a "reached limit" flag.
module contador_saturado #(
    parameter int unsigned LARGURA_CNT = 8,
    parameter int unsigned LIMITE      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   inc_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    output logic [LARGURA_CNT-1:0] valor_o,
    output logic                   cheio_o
);

    localparam logic [LARGURA_CNT-1:0] Limite = LARGURA_CNT'(LIMITE);
    localparam logic [LARGURA_CNT-1:0] Um     = LARGURA_CNT'(1);

    logic [LARGURA_CNT-1:0] valor_q, valor_d;

    always_comb begin
        valor_d = valor_q;
        if (clr_i) begin
            valor_d = '0;
        end else if (load_i) begin
            valor_d = Um;
        end else if (inc_i && (valor_q != Limite)) begin
            valor_d = valor_q + Um;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor_o = valor_q;
    assign cheio_o = (valor_q == Limite);

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter: pipeline (P) has fixed priority, external port (X) gets
// anti-starvation promotion and optional locked bursts.
module arbitro_memoria_dados
    import pkg_memoria::*;
#(
    parameter int unsigned LARGURA    = LARGURA_DADOS,
    parameter int unsigned MAX_ESPERA = 4,
    parameter int unsigned MAX_RAJADA = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    arbitro_memoria_dados_if.slave  bus
);

    localparam int unsigned        LargCnt      = 8;
    localparam logic [LargCnt-1:0] UltimaRajada = LargCnt'(MAX_RAJADA - 1);

    t_estado_arb        estado_q, estado_d;
    logic               grant_p, grant_x;
    logic               espera_inc, espera_clr, espera_cheio;
    logic               rajada_inc, rajada_load, rajada_cheio;
    logic [LargCnt-1:0] espera_valor, rajada_valor;
    logic [LARGURA-1:0] end_q, end_d, ent_q, ent_d;
    logic               hab_escrita;
    logic               pronto_p_q, pronto_x_q;
    logic               unused_contadores;

    always_comb begin
        estado_d    = estado_q;
        grant_p     = 1'b0;
        grant_x     = 1'b0;
        rajada_inc  = 1'b0;
        rajada_load = 1'b0;
        unique case (estado_q)
            LIVRE: begin
                grant_x = bus.req_x && (!bus.req_p || espera_cheio);
                grant_p = bus.req_p && !grant_x;
                // A one-grant burst limit means the lock can never actually be held.
                if (grant_x && bus.trava_x && (MAX_RAJADA > 1)) begin
                    estado_d    = RAJADA_X;
                    rajada_load = 1'b1;
                end
            end
            RAJADA_X: begin
                grant_x    = bus.req_x;
                rajada_inc = bus.req_x;
                if (!bus.req_x || !bus.trava_x || (rajada_valor == UltimaRajada)) begin
                    estado_d = LIVRE;
                end
            end
            default: estado_d = LIVRE;
        endcase
        if (reset) begin
            grant_p = 1'b0;
            grant_x = 1'b0;
        end
        espera_inc = bus.req_x && !grant_x;
        espera_clr = grant_x || !bus.req_x;
    end

    contador_saturado #(
        .LARGURA_CNT (LargCnt),
        .LIMITE      (MAX_ESPERA)
    ) u_espera (
        .clk_i   (clock),
        .rst_i   (reset),
        .inc_i   (espera_inc),
        .clr_i   (espera_clr),
        .load_i  (1'b0),
        .valor_o (espera_valor),
        .cheio_o (espera_cheio)
    );

    contador_saturado #(
        .LARGURA_CNT (LargCnt),
        .LIMITE      (MAX_RAJADA)
    ) u_rajada (
        .clk_i   (clock),
        .rst_i   (reset),
        .inc_i   (rajada_inc),
        .clr_i   (1'b0),
        .load_i  (rajada_load),
        .valor_o (rajada_valor),
        .cheio_o (rajada_cheio)
    );

    assign unused_contadores = ^{espera_valor, rajada_cheio};

    // With no grant the address/data lines keep their previous values.
    always_comb begin
        end_d       = end_q;
        ent_d       = ent_q;
        hab_escrita = 1'b0;
        if (grant_x) begin
            end_d       = bus.end_x;
            ent_d       = bus.dado_x;
            hab_escrita = bus.esc_x;
        end else if (grant_p) begin
            end_d       = bus.end_p;
            ent_d       = bus.dado_p;
            hab_escrita = bus.esc_p;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= LIVRE;
            end_q      <= '0;
            ent_q      <= '0;
            pronto_p_q <= 1'b0;
            pronto_x_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            end_q      <= end_d;
            ent_q      <= ent_d;
            pronto_p_q <= grant_p;
            pronto_x_q <= grant_x;
        end
    end

    assign bus.md_hab_escrita = hab_escrita && !reset;
    assign bus.md_endereco    = end_d;
    assign bus.md_entrada     = ent_d;
    assign bus.stall_p        = bus.req_p && !grant_p && !reset;
    assign bus.conc_x         = grant_x;
    assign bus.pronto_p       = pronto_p_q;
    assign bus.pronto_x       = pronto_x_q;
    assign bus.dado_lido      = bus.md_saida;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados with a behavioural synchronous memory.
module tb_arbitro_memoria_dados;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [15:0] Z = 16'h0000;

    typedef struct {
        logic        req_p, esc_p;
        logic [15:0] end_p, dado_p;
        logic        req_x, esc_x;
        logic [15:0] end_x, dado_x;
        logic        trava_x;
        logic        e_stall, e_conc, e_we;
        logic [15:0] e_end, e_ent;
        logic        e_pp, e_px, chk_dado;
        logic [15:0] e_dado;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] mem [256];

    arbitro_memoria_dados_if #(.LARGURA(16)) bus ();

    arbitro_memoria_dados #(
        .LARGURA    (16),
        .MAX_ESPERA (4),
        .MAX_RAJADA (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    end

    always @(posedge clock) begin
        if (bus.md_hab_escrita) mem[bus.md_endereco[7:0]] <= bus.md_entrada;
        bus.md_saida <= mem[bus.md_endereco[7:0]];
    end

    function automatic vec_t mk(input logic rp, ep, input logic [15:0] ap, dp,
                                input logic rx, ex, input logic [15:0] ax, dx, input logic tx,
                                input logic es, ec, ew, input logic [15:0] ee, en,
                                input logic pp, px, cd, input logic [15:0] ed);
        vec_t v;
        v.req_p = rp; v.esc_p = ep; v.end_p = ap; v.dado_p = dp;
        v.req_x = rx; v.esc_x = ex; v.end_x = ax; v.dado_x = dx; v.trava_x = tx;
        v.e_stall = es; v.e_conc = ec; v.e_we = ew; v.e_end = ee; v.e_ent = en;
        v.e_pp = pp; v.e_px = px; v.chk_dado = cd; v.e_dado = ed;
        return v;
    endfunction

    task automatic check(input string nome, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    task automatic drive(input logic rp, ep, input logic [15:0] ap, dp,
                         input logic rx, ex, input logic [15:0] ax, dx, input logic tx);
        bus.req_p = rp; bus.esc_p = ep; bus.end_p = ap; bus.dado_p = dp;
        bus.req_x = rx; bus.esc_x = ex; bus.end_x = ax; bus.dado_x = dx; bus.trava_x = tx;
    endtask

    task automatic idle();
        drive(L, L, Z, Z, L, L, Z, Z, L);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Both requesters active for n cycles; X expected granted where the mask bit is set.
    task automatic contention(input string nome, input int n, input logic [31:0] mask_x,
                              input logic [31:0] mask_trava);
        logic prev_x, prev_p, ex;
        prev_x = 1'b0;
        prev_p = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(H, L, 16'h0070, Z, H, H, 16'h0080 + 16'(i), 16'(i), mask_trava[i]);
            ex = mask_x[i];
            #1;
            check({nome, " conc_x"}, bus.conc_x, ex);
            check({nome, " stall_p"}, bus.stall_p, ex);
            check({nome, " we"}, bus.md_hab_escrita, ex);
            check({nome, " end"}, bus.md_endereco, ex ? 16'h0080 + 16'(i) : 16'h0070);
            check({nome, " pronto_x"}, bus.pronto_x, prev_x);
            check({nome, " pronto_p"}, bus.pronto_p, prev_p);
            prev_x = ex;
            prev_p = !ex;
            @(negedge clock);
        end
    endtask

    vec_t tab [10];

    initial begin
        checks = 0;
        errors = 0;

        tab[0] = mk(H, H, 16'h0010, 16'hBEEF, L, L, Z, Z, L,
                    L, L, H, 16'h0010, 16'hBEEF, L, L, L, Z);
        tab[1] = mk(H, L, 16'h0010, Z, L, L, Z, Z, L,
                    L, L, L, 16'h0010, Z, H, L, L, Z);
        tab[2] = mk(L, L, Z, Z, L, L, Z, Z, L,
                    L, L, L, 16'h0010, Z, H, L, H, 16'hBEEF);
        tab[3] = mk(L, L, Z, Z, H, H, 16'h0030, 16'h1111, L,
                    L, H, H, 16'h0030, 16'h1111, L, L, L, Z);
        tab[4] = mk(L, L, Z, Z, L, L, Z, Z, L,
                    L, L, L, 16'h0030, 16'h1111, L, H, L, Z);
        tab[5] = mk(L, L, Z, Z, L, L, Z, Z, L,
                    L, L, L, 16'h0030, 16'h1111, L, L, L, Z);
        tab[6] = mk(L, L, Z, Z, L, L, Z, Z, L,
                    L, L, L, 16'h0030, 16'h1111, L, L, L, Z);
        tab[7] = mk(L, L, Z, Z, H, L, 16'h0030, 16'h2222, L,
                    L, H, L, 16'h0030, 16'h2222, L, L, L, Z);
        tab[8] = mk(L, L, Z, Z, L, L, Z, Z, L,
                    L, L, L, 16'h0030, 16'h2222, L, H, H, 16'h1111);
        tab[9] = mk(H, H, 16'h0040, 16'hAAAA, H, H, 16'h0050, 16'h5555, L,
                    L, L, H, 16'h0040, 16'hAAAA, L, L, L, Z);

        // Outputs are suppressed while reset is high, even with both requesting.
        reset = 1'b1;
        drive(H, H, 16'h0011, 16'h1234, H, H, 16'h0022, 16'h4321, L);
        #1;
        check("rst stall_p", bus.stall_p, L);
        check("rst conc_x", bus.conc_x, L);
        check("rst we", bus.md_hab_escrita, L);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle();
        #1;
        check("rst pronto_p", bus.pronto_p, L);
        check("rst pronto_x", bus.pronto_x, L);
        check("rst end", bus.md_endereco, Z);
        check("rst ent", bus.md_entrada, Z);
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            drive(tab[i].req_p, tab[i].esc_p, tab[i].end_p, tab[i].dado_p, tab[i].req_x,
                  tab[i].esc_x, tab[i].end_x, tab[i].dado_x, tab[i].trava_x);
            #1;
            check($sformatf("v%0d stall_p", i), bus.stall_p, tab[i].e_stall);
            check($sformatf("v%0d conc_x", i), bus.conc_x, tab[i].e_conc);
            check($sformatf("v%0d we", i), bus.md_hab_escrita, tab[i].e_we);
            check($sformatf("v%0d end", i), bus.md_endereco, tab[i].e_end);
            check($sformatf("v%0d ent", i), bus.md_entrada, tab[i].e_ent);
            check($sformatf("v%0d pronto_p", i), bus.pronto_p, tab[i].e_pp);
            check($sformatf("v%0d pronto_x", i), bus.pronto_x, tab[i].e_px);
            if (tab[i].chk_dado) check($sformatf("v%0d dado_lido", i), bus.dado_lido, tab[i].e_dado);
            @(negedge clock);
        end

        // Starvation: X promoted every 5th cycle.
        pulse_reset();
        contention("espera", 15, 32'b100001000010000, 32'h0);

        // Locked burst: promoted at cycle 4, holds 8 grants, P back at cycle 12.
        pulse_reset();
        contention("rajada", 13, 32'b0111111110000, 32'h1FFF);

        // Burst ended by trava_x low on the 3rd grant; waiting count restarts from zero.
        pulse_reset();
        contention("rajada_curta", 12, 32'b100001110000, 32'b000000111111);

        // Reset coinciding with a P write must not write memory nor produce pronto.
        pulse_reset();
        drive(H, H, 16'h0020, 16'h5A5A, L, L, Z, Z, L);
        #1;
        check("rw we", bus.md_hab_escrita, H);
        @(negedge clock);
        reset = 1'b1;
        drive(H, H, 16'h0020, 16'h1234, L, L, Z, Z, L);
        #1;
        check("rw rst we", bus.md_hab_escrita, L);
        check("rw rst stall_p", bus.stall_p, L);
        @(negedge clock);
        reset = 1'b0;
        idle();
        #1;
        check("rw pronto_p", bus.pronto_p, L);
        @(negedge clock);
        drive(H, L, 16'h0020, Z, L, L, Z, Z, L);
        #1;
        check("rw rd end", bus.md_endereco, 16'h0020);
        check("rw rd we", bus.md_hab_escrita, L);
        @(negedge clock);
        idle();
        #1;
        check("rw rd pronto_p", bus.pronto_p, H);
        check("rw rd dado_lido", bus.dado_lido, 16'h5A5A);
        @(negedge clock);

        // Idle cycles keep the last address.
        for (int i = 0; i < 3; i++) begin
            idle();
            #1;
            check($sformatf("idle%0d we", i), bus.md_hab_escrita, L);
            check($sformatf("idle%0d pronto_p", i), bus.pronto_p, L);
            check($sformatf("idle%0d pronto_x", i), bus.pronto_x, L);
            check($sformatf("idle%0d end", i), bus.md_endereco, 16'h0020);
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
